// File: rtl/riscv_pkg.sv
// riscv_pkg: fetch-stage types and constants shared by the instruction-memory controller.
package riscv_pkg;
  typedef enum logic [1:0] {LOAD, RUN, DRAIN, HALT} fetch_state_e;
  localparam int INSTR_BYTES = 4;
  localparam int DEFAULT_START_PC = 4;
endpackage

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: byte-serial program load into instruction memory, then PC-driven fetch to decode.
module imem_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int AW = 8,
  parameter int START_PC = DEFAULT_START_PC
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [7:0]    mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          id_ready,
  input  logic          branch_valid,
  input  logic [AW-1:0] branch_target,
  output logic          halted,
  output logic          load_ovf,
  output logic          misalign
);
  fetch_state_e  state_q;
  logic [AW:0]   pc_q, prog_end_q;
  logic [AW-1:0] ld_ptr_q, instr_pc_q;
  logic [31:0]   instr_q;
  logic          instr_valid_q, halted_q, load_ovf_q, misalign_q;
  logic          fits, fire;
  // PC and program end carry one extra bit so a program filling all of memory ends at 2**AW.
  assign fits = (pc_q + (AW+1)'(INSTR_BYTES)) <= prog_end_q;
  assign fire = (state_q == RUN) && (!instr_valid_q || id_ready) && fits;
  assign ld_ready = state_q == LOAD;
  assign mem_we = ld_ready && ld_valid;
  assign mem_waddr = ld_ptr_q;
  assign mem_wdata = ld_byte;
  assign mem_raddr = pc_q[AW-1:0];
  assign instr = instr_q;
  assign instr_pc = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted = halted_q;
  assign load_ovf = load_ovf_q;
  assign misalign = misalign_q;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= LOAD;
      pc_q <= (AW+1)'(START_PC);
      prog_end_q <= '0;
      ld_ptr_q <= '0;
      instr_q <= '0;
      instr_pc_q <= '0;
      instr_valid_q <= 1'b0;
      halted_q <= 1'b0;
      load_ovf_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: if (ld_valid) begin
          ld_ptr_q <= ld_ptr_q + AW'(1);
          if (ld_last) begin
            prog_end_q <= {1'b0, ld_ptr_q} + (AW+1)'(1);
            state_q <= RUN;
          end else if (&ld_ptr_q) begin
            load_ovf_q <= 1'b1;
            prog_end_q <= (AW+1)'(2**AW);
            state_q <= RUN;
          end
        end
        RUN, DRAIN: if (branch_valid) begin
          instr_valid_q <= 1'b0;
          pc_q <= {1'b0, branch_target[AW-1:2], 2'b00};
          state_q <= RUN;
          if (|branch_target[1:0]) misalign_q <= 1'b1;
        end else if (state_q == RUN) begin
          if (fire) begin
            instr_q <= mem_rdata;
            instr_pc_q <= pc_q[AW-1:0];
            instr_valid_q <= 1'b1;
            pc_q <= pc_q + (AW+1)'(INSTR_BYTES);
          end else begin
            if (id_ready) instr_valid_q <= 1'b0;
            if (!fits) state_q <= DRAIN;
          end
        end else if (!instr_valid_q || id_ready) begin
          instr_valid_q <= 1'b0;
          halted_q <= 1'b1;
          state_q <= HALT;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed load/fetch/branch scenarios checked against a cycle model of the controller.
module tb_imem_fetch_ctrl;
  logic clock = 0, reset = 0, ld_valid = 0, ld_last = 0, id_ready = 0, branch_valid = 0;
  logic [7:0] ld_byte = 0, branch_target = 0;
  logic ld_ready, mem_we, instr_valid, halted, load_ovf, misalign;
  logic [7:0] mem_waddr, mem_wdata, mem_raddr, instr_pc;
  logic [31:0] mem_rdata, instr;
  logic [7:0] tmem[256];
  logic [7:0] mm[256];
  int n_cmp = 0, n_err = 0, we_cnt = 0;
  logic [39:0] acc[$];
  logic [31:0] prog[7];
  int m_mode, m_pc, m_end, m_ptr, m_ipc;
  bit m_v, m_halt, m_ovf, m_mis, m_init = 0;
  logic [31:0] m_instr;

  imem_fetch_ctrl #(.AW(8), .START_PC(4)) dut (
    .clock(clock), .reset(reset), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(ld_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .id_ready(id_ready), .branch_valid(branch_valid),
    .branch_target(branch_target), .halted(halted), .load_ovf(load_ovf), .misalign(misalign)
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (mem_we) tmem[mem_waddr] <= mem_wdata;
  assign mem_rdata = {tmem[mem_raddr + 8'd3], tmem[mem_raddr + 8'd2], tmem[mem_raddr + 8'd1], tmem[mem_raddr]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: spec rules in plain integer arithmetic, advanced on each rising edge.
  always @(posedge clock) begin
    if (!reset) begin
      m_init = 1; m_mode = 0; m_pc = 4; m_ptr = 0; m_end = 0; m_v = 0;
      m_instr = 0; m_ipc = 0; m_halt = 0; m_ovf = 0; m_mis = 0;
    end else if (m_mode == 0) begin
      if (ld_valid) begin
        mm[m_ptr] = ld_byte;
        if (ld_last) begin m_end = m_ptr + 1; m_mode = 1; end
        else if (m_ptr == 255) begin m_ovf = 1; m_end = 256; m_mode = 1; end
        m_ptr = (m_ptr + 1) % 256;
      end
    end else if (m_mode != 3 && branch_valid) begin
      m_v = 0; m_pc = int'(branch_target) / 4 * 4; m_mode = 1;
      if (branch_target % 4 != 0) m_mis = 1;
    end else if (m_mode == 1) begin
      if ((!m_v || id_ready) && m_pc + 4 <= m_end) begin
        m_instr = {mm[m_pc+3], mm[m_pc+2], mm[m_pc+1], mm[m_pc]};
        m_ipc = m_pc; m_v = 1; m_pc += 4;
      end else begin
        if (id_ready) m_v = 0;
        if (m_pc + 4 > m_end) m_mode = 2;
      end
    end else if (m_mode == 2 && (!m_v || id_ready)) begin
      m_v = 0; m_mode = 3; m_halt = 1;
    end
  end

  always @(negedge clock) if (m_init) begin
    chk("instr_valid", 32'(instr_valid), 32'(m_v));
    if (m_v) begin
      chk("instr", instr, m_instr);
      chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
    end
    chk("halted", 32'(halted), 32'(m_halt));
    chk("load_ovf", 32'(load_ovf), 32'(m_ovf));
    chk("misalign", 32'(misalign), 32'(m_mis));
    chk("ld_ready", 32'(ld_ready), 32'(m_mode == 0));
    chk("mem_we", 32'(mem_we), 32'(m_mode == 0 && ld_valid));
    if (m_mode == 0 && ld_valid) begin
      chk("mem_waddr", 32'(mem_waddr), 32'(m_ptr));
      chk("mem_wdata", 32'(mem_wdata), 32'(ld_byte));
    end
    if (m_mode == 1 || m_mode == 2) chk("mem_raddr", 32'(mem_raddr), 32'(m_pc % 256));
    if (instr_valid && id_ready) acc.push_back({instr_pc, instr});
    if (mem_we) we_cnt++;
  end

  task automatic step();
    @(posedge clock); #2;
  endtask

  task automatic do_reset();
    reset = 0; ld_valid = 0; ld_last = 0; branch_valid = 0; id_ready = 1;
    step(); step();
    reset = 1; acc.delete(); we_cnt = 0;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1; ld_byte = prog[i/4][8*(i%4)+:8]; ld_last = (i == n - 1);
      step();
    end
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic wait_halt(input int bound);
    for (int i = 0; i < bound && !halted; i++) step();
    chk("halt_timeout", 32'(halted), 32'd1);
  endtask

  task automatic wait_pc(input string name, input logic [7:0] pc);
    int i;
    for (i = 0; i < 40 && !(instr_valid && instr_pc == pc); i++) step();
    chk(name, 32'(i < 40), 32'd1);
  endtask

  task automatic chk_acc(input string name, input int idx, input logic [7:0] pc, input logic [31:0] w);
    chk(name, (idx < acc.size()) ? 32'(acc[idx][39:32]) : 32'hdead, 32'(pc));
    chk(name, (idx < acc.size()) ? acc[idx][31:0] : 32'hdeadbeef, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 256; i++) tmem[i] = 0;
    prog = '{32'h00000013, 32'h00940333, 32'h412983b3, 32'h00f768b3,
             32'h00d67fb3, 32'h017b4e33, 32'h01bd2f33};
    // 1: full program, decode always ready
    do_reset();
    load(28);
    wait_halt(30);
    chk("t1_we_pulses", 32'(we_cnt), 32'd28);
    chk("t1_count", 32'(acc.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk_acc("t1_seq", i, 8'(4 + 4*i), prog[i+1]);
    // 2: decode stalls for three cycles on the instruction at 8
    do_reset();
    load(28);
    wait_pc("t2_reach8", 8'd8);
    id_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold", instr, 32'h412983b3);
    end
    id_ready = 1;
    wait_halt(30);
    chk("t2_count", 32'(acc.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk_acc("t2_seq", i, 8'(4 + 4*i), prog[i+1]);
    // 3: branch colliding with the fetch at 8, then a misaligned branch
    do_reset();
    load(28);
    wait_pc("t3_reach4", 8'd4);
    branch_valid = 1; branch_target = 8'd16;
    step();
    branch_valid = 0;
    chk("t3_flush", 32'(instr_valid), 32'd0);
    step();
    chk("t3_tgt_pc", 32'(instr_pc), 32'd16);
    chk("t3_tgt_instr", instr, 32'h00d67fb3);
    wait_pc("t3_reach20", 8'd20);
    branch_valid = 1; branch_target = 8'd18;
    step();
    branch_valid = 0;
    chk("t3_misalign", 32'(misalign), 32'd1);
    step();
    chk("t3_mis_pc", 32'(instr_pc), 32'd16);
    wait_halt(30);
    chk("t3_count", 32'(acc.size()), 32'd6);
    k = 0;
    foreach (prog[i]) if (i == 1 || i == 4 || i == 5) k++;
    chk_acc("t3_seq0", 0, 8'd4, prog[1]);
    chk_acc("t3_seq1", 1, 8'd16, prog[4]);
    chk_acc("t3_seq2", 2, 8'd20, prog[5]);
    chk_acc("t3_seq3", 3, 8'd16, prog[4]);
    chk_acc("t3_seq5", 5, 8'd24, prog[6]);
    // 4: 256 bytes without ld_last overflows memory; branch during load is ignored
    do_reset();
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1; ld_byte = 8'(i); ld_last = 0; branch_valid = (i == 10); branch_target = 8'h40;
      step();
    end
    ld_valid = 0; branch_valid = 0;
    chk("t4_ovf", 32'(load_ovf), 32'd1);
    chk("t4_ld_ready", 32'(ld_ready), 32'd0);
    wait_halt(100);
    chk("t4_count", 32'(acc.size()), 32'd63);
    chk_acc("t4_first", 0, 8'd4, 32'h07060504);
    chk_acc("t4_last", 62, 8'd252, 32'hfffefdfc);
    // 5: reset during run at PC=12
    do_reset();
    load(28);
    for (k = 0; k < 40 && !(!ld_ready && mem_raddr == 8'd12); k++) step();
    chk("t5_reach12", 32'(k < 40), 32'd1);
    reset = 0;
    step();
    chk("t5_valid", 32'(instr_valid), 32'd0);
    chk("t5_ld_ready", 32'(ld_ready), 32'd1);
    chk("t5_pc", 32'(mem_raddr), 32'd4);
    reset = 1;
    step();
    // 6: 26-byte program leaves the word at 24 partial, so it is never fetched
    do_reset();
    load(26);
    wait_halt(30);
    chk("t6_count", 32'(acc.size()), 32'd5);
    chk_acc("t6_last", 4, 8'd20, prog[5]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
